multi_button_debouncer: RTL

//  Debounces NUM_CH independent mechanical buttons sharing one clk domain. Per

---
 rtl/multi_button_debouncer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/multi_button_debouncer.sv
// Multi-channel button debouncer: per-channel synchroniser, debounce filter,
// press/release pulses, long-press detection and optional auto-repeat.
module multi_button_debouncer #(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned ACTIVE_LOW        = 1,
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 1000000,
    parameter int unsigned REPEAT_CYCLES     = 200000,
    parameter int unsigned CNT_W             = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] raw_buttons,
    input  logic              repeat_en,
    output logic [NUM_CH-1:0] button_state,
    output logic [NUM_CH-1:0] on_button_down,
    output logic [NUM_CH-1:0] on_button_up,
    output logic [NUM_CH-1:0] on_long_press,
    output logic [NUM_CH-1:0] on_repeat
);

    localparam logic             RELEASED_RAW = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST    = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST     = CNT_W'(REPEAT_CYCLES - 1);
    localparam longint unsigned  CNT_LIMIT    = (CNT_W >= 1 && CNT_W <= 32) ?
                                                (64'd1 << CNT_W) : 64'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    // Reject parameter sets the timers cannot represent
    if (NUM_CH < 1) begin : g_err_num_ch
        $error("multi_button_debouncer: NUM_CH must be >= 1");
    end
    if (ACTIVE_LOW > 1) begin : g_err_active_low
        $error("multi_button_debouncer: ACTIVE_LOW must be 0 or 1");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_err_cnt_w
        $error("multi_button_debouncer: CNT_W must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) > CNT_LIMIT) begin : g_err_db
        $error("multi_button_debouncer: DEBOUNCE_CYCLES out of range for CNT_W");
    end
    if (LONG_PRESS_CYCLES < 1 || 64'(LONG_PRESS_CYCLES) > CNT_LIMIT) begin : g_err_long
        $error("multi_button_debouncer: LONG_PRESS_CYCLES out of range for CNT_W");
    end
    if (REPEAT_CYCLES < 1 || 64'(REPEAT_CYCLES) > CNT_LIMIT) begin : g_err_rep
        $error("multi_button_debouncer: REPEAT_CYCLES out of range for CNT_W");
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        logic [CNT_W-1:0] r_db_cnt;
        logic [CNT_W-1:0] r_hold_cnt;
        logic             r_btn;
        logic             r_down;
        logic             r_up;
        logic             r_long;
        logic             r_rep;
        state_t           r_state;

        logic             w_level;
        logic             w_mismatch;
        logic             w_accept;

        // Synchronised pin normalised so that 1 = pressed
        assign w_level    = r_sync2 ^ RELEASED_RAW;
        assign w_mismatch = (w_level != r_btn);
        assign w_accept   = w_mismatch && (r_db_cnt == DB_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync1    <= RELEASED_RAW;
                r_sync2    <= RELEASED_RAW;
                r_db_cnt   <= '0;
                r_hold_cnt <= '0;
                r_btn      <= 1'b0;
                r_down     <= 1'b0;
                r_up       <= 1'b0;
                r_long     <= 1'b0;
                r_rep      <= 1'b0;
                r_state    <= ST_IDLE;
            end else begin
                r_sync1 <= raw_buttons[g];
                r_sync2 <= r_sync1;
                r_down  <= 1'b0;
                r_up    <= 1'b0;
                r_long  <= 1'b0;
                r_rep   <= 1'b0;

                // Any agreement with the accepted level discards the partial run
                if (!w_mismatch) begin
                    r_db_cnt <= '0;
                end else if (w_accept) begin
                    r_db_cnt <= '0;
                    r_btn    <= w_level;
                    r_down   <= w_level;
                    r_up     <= ~w_level;
                end else begin
                    r_db_cnt <= r_db_cnt + CNT_W'(1);
                end

                // Accepted release wins over a coincident long-press/repeat expiry
                case (r_state)
                    ST_IDLE: begin
                        r_hold_cnt <= '0;
                        if (w_accept && w_level) begin
                            r_state <= ST_PRESSED;
                        end
                    end
                    ST_PRESSED: begin
                        if (w_accept) begin
                            r_state    <= ST_IDLE;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == LONG_LAST) begin
                            r_state    <= ST_HELD;
                            r_long     <= 1'b1;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                        end
                    end
                    ST_HELD: begin
                        if (w_accept) begin
                            r_state    <= ST_IDLE;
                            r_hold_cnt <= '0;
                        end else if (r_hold_cnt == REP_LAST) begin
                            r_rep      <= repeat_en;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_hold_cnt <= '0;
                    end
                endcase
            end
        end

        assign button_state[g]   = r_btn;
        assign on_button_down[g] = r_down;
        assign on_button_up[g]   = r_up;
        assign on_long_press[g]  = r_long;
        assign on_repeat[g]      = r_rep;
    end

endmodule
